exc_commit_ctrl: RTL and testbench

//  Commit-stage exception/ERET controller; the producer side of the CP0 exception-update interface.

---
 rtl/exc_commit_ctrl_if.sv | 27 ++
 rtl/exc_commit_ctrl.sv | 133 +++++++++++++
 tb/tb_exc_commit_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/exc_commit_ctrl_if.sv
// CP0 exception-update bus plus the fetch-redirect valid/ready handshake.
// The commit controller is the master: it drives everything except redir_ready.
interface exc_commit_ctrl_if;
    logic        cp0_update_ena;
    logic [4:0]  cp0_exccode;
    logic        cp0_bd;
    logic        cp0_exl;
    logic [31:0] cp0_epc;
    logic        cp0_badva_ena;
    logic [31:0] cp0_badva;
    logic        cp0_cls_exl;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;

    modport master (
        output cp0_update_ena, cp0_exccode, cp0_bd, cp0_exl, cp0_epc,
        output cp0_badva_ena, cp0_badva, cp0_cls_exl, redir_valid, redir_pc,
        input  redir_ready
    );

    modport slave (
        input  cp0_update_ena, cp0_exccode, cp0_bd, cp0_exl, cp0_epc,
        input  cp0_badva_ena, cp0_badva, cp0_cls_exl, redir_valid, redir_pc,
        output redir_ready
    );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Commit-stage exception/ERET controller: picks one event, strobes CP0, flushes, redirects fetch.
// Optional taken-exception counter is built only when EXC_COUNT_EN is defined.
module exc_commit_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] BD_EPC_OFF = 32'd4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_cmt_valid,
    input  logic [31:0]               i_cmt_pc,
    input  logic                      i_cmt_bd,
    input  logic [6:0]                i_cmt_exc,
    input  logic                      i_cmt_eret,
    input  logic [31:0]               i_cmt_data_badva,
    input  logic                      i_int_pending,
    input  logic [31:0]               i_cp0_epc_in,
    exc_commit_ctrl_if.master         bus,
    output logic                      o_flush,
    output logic                      o_cmt_stall,
    output logic [31:0]               o_exc_count
);

    typedef enum logic {S_IDLE, S_REDIRECT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_start;
    logic        w_exc_win;
    logic [4:0]  w_code;
    logic        w_bva_sel;
    logic [31:0] w_bva;
    logic [31:0] w_epc;

    logic        r_update_ena;
    logic [4:0]  r_exccode;
    logic        r_bd;
    logic        r_exl;
    logic [31:0] r_epc;
    logic        r_badva_ena;
    logic [31:0] r_badva;
    logic        r_cls_exl;
    logic        r_flush;
    logic [31:0] r_redir_pc;

    assign w_start = (r_state == S_IDLE) && i_cmt_valid &&
                     (i_int_pending || (|i_cmt_exc) || i_cmt_eret);
    assign w_epc   = i_cmt_bd ? (i_cmt_pc - BD_EPC_OFF) : i_cmt_pc;

    // Exception bits are {ades,adel_d,ov,bp,sys,ri,adel_if}; ERET is the fall-through.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_exc_win = 1'b1;
        w_code    = 5'd0;
        w_bva_sel = 1'b0;
        w_bva     = i_cmt_pc;
        if (i_int_pending)     w_code = 5'd0;
        else if (i_cmt_exc[0]) begin w_code = 5'd4; w_bva_sel = 1'b1; end
        else if (i_cmt_exc[1]) w_code = 5'd10;
        else if (i_cmt_exc[4]) w_code = 5'd12;
        else if (i_cmt_exc[2]) w_code = 5'd8;
        else if (i_cmt_exc[3]) w_code = 5'd9;
        else if (i_cmt_exc[5]) begin w_code = 5'd4; w_bva_sel = 1'b1; w_bva = i_cmt_data_badva; end
        else if (i_cmt_exc[6]) begin w_code = 5'd5; w_bva_sel = 1'b1; w_bva = i_cmt_data_badva; end
        else                   w_exc_win = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_start) w_state_nxt = S_REDIRECT;
            S_REDIRECT: if (bus.redir_ready) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_update_ena <= 1'b0;
            r_exccode    <= 5'd0;
            r_bd         <= 1'b0;
            r_exl        <= 1'b0;
            r_epc        <= 32'd0;
            r_badva_ena  <= 1'b0;
            r_badva      <= 32'd0;
            r_cls_exl    <= 1'b0;
            r_flush      <= 1'b0;
            r_redir_pc   <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_update_ena <= w_start && w_exc_win;
            r_badva_ena  <= w_start && w_exc_win && w_bva_sel;
            r_cls_exl    <= w_start && !w_exc_win;
            r_flush      <= w_start;
            if (w_start && w_exc_win) begin
                r_exccode <= w_code;
                r_bd      <= i_cmt_bd;
                r_exl     <= 1'b1;
                r_epc     <= w_epc;
            end
            if (w_start && w_exc_win && w_bva_sel) r_badva <= w_bva;
            if (w_start) r_redir_pc <= w_exc_win ? EXC_VECTOR : i_cp0_epc_in;
        end
    end

`ifdef EXC_COUNT_EN
    logic [31:0] r_exc_count;

    always_ff @(posedge clk) begin
        if (rst)                    r_exc_count <= 32'd0;
        else if (w_start && w_exc_win) r_exc_count <= r_exc_count + 32'd1;
    end

    assign o_exc_count = r_exc_count;
`else
    assign o_exc_count = 32'd0;
`endif

    assign bus.cp0_update_ena = r_update_ena;
    assign bus.cp0_exccode    = r_exccode;
    assign bus.cp0_bd         = r_bd;
    assign bus.cp0_exl        = r_exl;
    assign bus.cp0_epc        = r_epc;
    assign bus.cp0_badva_ena  = r_badva_ena;
    assign bus.cp0_badva      = r_badva;
    assign bus.cp0_cls_exl    = r_cls_exl;
    assign bus.redir_valid    = (r_state == S_REDIRECT);
    assign bus.redir_pc       = r_redir_pc;
    assign o_flush            = r_flush;
    assign o_cmt_stall        = (r_state == S_REDIRECT);

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed cases then randomized commits against a priority-table model.
// Define EXC_COUNT_EN for both bench and RTL to exercise the counter build.
module tb_exc_commit_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    typedef struct {
        bit          ev;
        bit          exc;
        logic [4:0]  code;
        bit          bva_en;
        logic [31:0] bva;
        logic [31:0] epc;
        logic [31:0] rpc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmt_valid, cmt_bd, cmt_eret, int_pending;
    logic [31:0] cmt_pc, cmt_data_badva, cp0_epc_in;
    logic [6:0]  cmt_exc;
    logic        flush, cmt_stall;
    logic [31:0] exc_count;

    int n_vec  = 0;
    int n_fail = 0;

    // held expectations for the CP0 data outputs and the counter
    logic [4:0]  h_code;
    logic        h_bd, h_exl;
    logic [31:0] h_epc, h_bva, h_cnt;

    exc_commit_ctrl_if bus ();

    exc_commit_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .i_cmt_valid      (cmt_valid),
        .i_cmt_pc         (cmt_pc),
        .i_cmt_bd         (cmt_bd),
        .i_cmt_exc        (cmt_exc),
        .i_cmt_eret       (cmt_eret),
        .i_cmt_data_badva (cmt_data_badva),
        .i_int_pending    (int_pending),
        .i_cp0_epc_in     (cp0_epc_in),
        .bus              (bus),
        .o_flush          (flush),
        .o_cmt_stall      (cmt_stall),
        .o_exc_count      (exc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Priority table walked in order; position 0 of the flag vector is adel_if.
    function automatic exp_t model(input logic v, input logic ip, input logic [6:0] ex,
                                   input logic er, input logic bd, input logic [31:0] pc,
                                   input logic [31:0] dva, input logic [31:0] ein);
        int    bits  [7] = '{0, 1, 4, 2, 3, 5, 6};
        int    codes [7] = '{4, 10, 12, 8, 9, 4, 5};
        exp_t  m;
        m.ev = v && (ip || ex != 0 || er);
        m.exc = 0; m.code = 0; m.bva_en = 0; m.bva = 0;
        m.epc = bd ? pc - 32'd4 : pc;
        m.rpc = ein;
        if (ip) m.exc = 1;
        else begin
            for (int i = 0; i < 7; i++) begin
                if (!m.exc && ex[bits[i]]) begin
                    m.exc  = 1;
                    m.code = 5'(codes[i]);
                    if (bits[i] == 0)      begin m.bva_en = 1; m.bva = pc;  end
                    else if (bits[i] >= 5) begin m.bva_en = 1; m.bva = dva; end
                end
            end
        end
        if (m.exc) m.rpc = VEC;
        return m;
    endfunction

    task automatic check_held(input string tag);
        check({tag, "_code"}, 32'(bus.cp0_exccode), 32'(h_code));
        check({tag, "_bd"},   32'(bus.cp0_bd),      32'(h_bd));
        check({tag, "_exl"},  32'(bus.cp0_exl),     32'(h_exl));
        check({tag, "_epc"},  bus.cp0_epc,          h_epc);
        check({tag, "_bva"},  bus.cp0_badva,        h_bva);
        check({tag, "_cnt"},  exc_count,            h_cnt);
    endtask

    task automatic check_quiet(input string tag, input logic exp_valid);
        check({tag, "_upd"},   32'(bus.cp0_update_ena), 32'd0);
        check({tag, "_bvaen"}, 32'(bus.cp0_badva_ena),  32'd0);
        check({tag, "_cls"},   32'(bus.cp0_cls_exl),    32'd0);
        check({tag, "_flush"}, 32'(flush),              32'd0);
        check({tag, "_rv"},    32'(bus.redir_valid),    32'(exp_valid));
        check({tag, "_stall"}, 32'(cmt_stall),          32'(exp_valid));
    endtask

    task automatic junk_inputs(input bit junk);
        cmt_valid   = junk;
        int_pending = junk ? 1'($urandom) : 1'b0;
        cmt_exc     = junk ? 7'($urandom) : 7'd0;
        cmt_eret    = junk ? 1'($urandom) : 1'b0;
        cmt_pc      = $urandom;
        cp0_epc_in  = $urandom;
    endtask

    // Called at a negedge; presents one commit and follows any redirect to completion.
    task automatic commit(input string tag, input logic v, input logic ip, input logic [6:0] ex,
                          input logic er, input logic bd, input logic [31:0] pc,
                          input logic [31:0] dva, input logic [31:0] ein,
                          input int wait_n, input bit junk);
        exp_t m;
        cmt_valid = v; int_pending = ip; cmt_exc = ex; cmt_eret = er;
        cmt_bd = bd; cmt_pc = pc; cmt_data_badva = dva; cp0_epc_in = ein;
        bus.redir_ready = 1'b0;
        m = model(v, ip, ex, er, bd, pc, dva, ein);
        @(negedge clk);
        if (!m.ev) begin
            check_quiet({tag, "_none"}, 1'b0);
            check_held({tag, "_none"});
            junk_inputs(1'b0);
            return;
        end
        if (m.exc) begin
            h_code = m.code; h_bd = bd; h_exl = 1'b1; h_epc = m.epc; h_cnt = h_cnt + 1;
`ifndef EXC_COUNT_EN
            h_cnt = 32'd0;
`endif
            if (m.bva_en) h_bva = m.bva;
        end
        check({tag, "_upd"},   32'(bus.cp0_update_ena), 32'(m.exc));
        check({tag, "_bvaen"}, 32'(bus.cp0_badva_ena),  32'(m.bva_en));
        check({tag, "_cls"},   32'(bus.cp0_cls_exl),    32'(!m.exc));
        check({tag, "_flush"}, 32'(flush),              32'd1);
        check({tag, "_rv"},    32'(bus.redir_valid),    32'd1);
        check({tag, "_rpc"},   bus.redir_pc,            m.rpc);
        check({tag, "_stall"}, 32'(cmt_stall),          32'd1);
        check_held(tag);
        junk_inputs(junk);
        bus.redir_ready = (wait_n == 0);
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            check_quiet({tag, "_hold"}, 1'b1);
            check({tag, "_hold_rpc"}, bus.redir_pc, m.rpc);
            check_held({tag, "_hold"});
            junk_inputs(junk);
            bus.redir_ready = (i == wait_n - 1);
        end
        @(negedge clk);
        check_quiet({tag, "_done"}, 1'b0);
        bus.redir_ready = 1'b0;
        junk_inputs(1'b0);
    endtask

    task automatic clear_model();
        h_code = 0; h_bd = 0; h_exl = 0; h_epc = 0; h_bva = 0; h_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.redir_ready = 1'b0;
        cmt_bd = 1'b0; cmt_data_badva = 32'd0;
        junk_inputs(1'b0);
        clear_model();
        repeat (2) @(negedge clk);
        check_quiet("reset", 1'b0);
        check_held("reset");
        check("reset_rpc", bus.redir_pc, 32'd0);
        rst = 1'b0;

        commit("idle_nop", 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 32'h80000000, 32'd0, 32'd0, 0, 1'b0);
        commit("no_valid", 1'b0, 1'b1, 7'h7F, 1'b1, 1'b0, 32'h80000000, 32'd0, 32'd0, 0, 1'b0);
        commit("sys", 1'b1, 1'b0, 7'b0000100, 1'b0, 1'b0, 32'h80001000, 32'd0, 32'd0, 0, 1'b0);
        commit("adel_d", 1'b1, 1'b0, 7'b0100000, 1'b0, 1'b1, 32'h80000204, 32'h3, 32'd0, 1, 1'b0);
        commit("eret", 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 32'h80000300, 32'd0, 32'h80002000, 0, 1'b0);
        commit("int_ri_eret", 1'b1, 1'b1, 7'b0000010, 1'b1, 1'b0, 32'h80000400, 32'd0, 32'h80002000, 3, 1'b1);
        commit("bd_wrap", 1'b1, 1'b0, 7'b0001000, 1'b0, 1'b1, 32'h00000002, 32'd0, 32'd0, 0, 1'b0);

        // reset while a redirect is outstanding
        cmt_valid = 1'b1; int_pending = 1'b0; cmt_exc = 7'b0010000; cmt_eret = 1'b0;
        cmt_bd = 1'b0; cmt_pc = 32'h80000500;
        @(negedge clk);
        check("pre_rst_rv", 32'(bus.redir_valid), 32'd1);
        cmt_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        clear_model();
        check_quiet("mid_rst", 1'b0);
        check_held("mid_rst");
        rst = 1'b0;

        commit("post_rst_ades", 1'b1, 1'b0, 7'b1000000, 1'b0, 1'b0, 32'h80000600, 32'h1234, 32'd0, 2, 1'b0);
        commit("cnt_ov", 1'b1, 1'b0, 7'b0010000, 1'b0, 1'b0, 32'h80000700, 32'd0, 32'd0, 0, 1'b0);
        commit("cnt_eret", 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 32'h80000800, 32'd0, 32'h80003000, 0, 1'b0);
        commit("cnt_adelif", 1'b1, 1'b0, 7'b0000001, 1'b0, 1'b0, 32'h80000901, 32'd0, 32'd0, 1, 1'b0);
`ifdef EXC_COUNT_EN
        check("cnt_three", exc_count, 32'd3);
`else
        check("cnt_tied", exc_count, 32'd0);
`endif

        for (int k = 0; k < 300; k++) begin
            commit("rand", ($urandom % 8) != 0, ($urandom % 5) == 0,
                   (($urandom % 3) == 0) ? 7'($urandom) : 7'd0, ($urandom % 4) == 0,
                   1'($urandom), $urandom, $urandom, $urandom, int'($urandom % 4), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
